// File: rtl/hazard_scoreboard.sv
// Hazard unit for the N-wide in-order core: pending-load scoreboard, intra-bundle
// issue masking, divider busy counter. Optional perf counters under HAZARD_PERF_EN.
module hazard_scoreboard #(
  parameter int ISSUE_W    = 2,
  parameter int LOAD_LAT   = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_stall,
  input  logic                 d_stall,
  input  logic [ISSUE_W-1:0]   D_valid,
  input  logic [5*ISSUE_W-1:0] D_rs,
  input  logic [5*ISSUE_W-1:0] D_rt,
  input  logic [5*ISSUE_W-1:0] D_waddr,
  input  logic [ISSUE_W-1:0]   D_is_load,
  input  logic                 D_div_start,
  input  logic                 E_branch_taken,
  input  logic                 M_except,
  output logic [ISSUE_W-1:0]   D_issue,
  output logic                 lw_stall,
  output logic                 div_busy,
  output logic                 longest_stall,
  output logic                 F_ena,
  output logic                 D_ena,
  output logic                 E_ena,
  output logic                 M_ena,
  output logic                 W_ena,
  output logic                 F_flush,
  output logic                 D_flush,
  output logic                 E_flush,
  output logic                 M_flush,
  output logic                 W_flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          perf_lw_stall_cnt,
  output logic [31:0]          perf_div_stall_cnt,
  output logic [31:0]          perf_partial_issue_cnt
`endif
);

  localparam int PW = $clog2(LOAD_LAT + 1);
  localparam int DW = $clog2(DIV_CYCLES + 1);
  localparam logic [PW-1:0] PEND_ZERO = PW'(0);
  localparam logic [PW-1:0] PEND_ONE  = PW'(1);
  localparam logic [PW-1:0] PEND_LOAD = PW'(LOAD_LAT);
  localparam logic [DW-1:0] DIV_ZERO  = DW'(0);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [DW-1:0] DIV_LOAD  = DW'(DIV_CYCLES);

  logic [PW-1:0]      pend_r     [32];
  logic [PW-1:0]      pend_nxt_s [32];
  logic [31:0]        pend_set_s;
  logic [DW-1:0]      div_cnt_r;
  logic [DW-1:0]      div_nxt_s;
  logic [ISSUE_W-1:0] hz_s;
  logic [ISSUE_W-1:0] dep_s;
  logic [ISSUE_W-1:0] issue_s;
  logic               longest_s;

  assign div_busy  = (div_cnt_r != DIV_ZERO);
  assign longest_s = i_stall | d_stall | div_busy;

  // Per-slot hazards: pending-load sources and reads of an earlier slot's destination
  always_comb begin
    hz_s  = '0;
    dep_s = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      hz_s[i] = (pend_r[D_rs[5*i +: 5]] != PEND_ZERO) | (pend_r[D_rt[5*i +: 5]] != PEND_ZERO);
      for (int j = 0; j < i; j++) begin
        dep_s[i] = dep_s[i] | (D_valid[j] & (D_waddr[5*j +: 5] != 5'd0) &
                   ((D_waddr[5*j +: 5] == D_rs[5*i +: 5]) | (D_waddr[5*j +: 5] == D_rt[5*i +: 5])));
      end
    end
  end

  // In-order issue chain: any blocked slot blocks every later slot
  always_comb begin
    issue_s    = '0;
    issue_s[0] = D_valid[0] & ~hz_s[0] & ~longest_s & ~E_branch_taken & ~M_except;
    for (int i = 1; i < ISSUE_W; i++) begin
      issue_s[i] = issue_s[i-1] & D_valid[i] & ~hz_s[i] & ~dep_s[i];
    end
  end

  // Scoreboard next state: exception clear beats a new load, which beats the decrement
  always_comb begin
    pend_set_s = 32'd0;
    for (int r = 1; r < 32; r++) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        pend_set_s[r] = pend_set_s[r] | (issue_s[i] & D_is_load[i] & (D_waddr[5*i +: 5] == 5'(r)));
      end
    end
    for (int r = 0; r < 32; r++) begin
      pend_nxt_s[r] = M_except      ? PEND_ZERO :
                      pend_set_s[r] ? PEND_LOAD :
                      (~longest_s && pend_r[r] != PEND_ZERO) ? (pend_r[r] - PEND_ONE) : pend_r[r];
    end
    pend_nxt_s[0] = PEND_ZERO;
  end

  // Scoreboard state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < 32; r++) pend_r[r] <= PEND_ZERO;
    end else begin
      for (int r = 0; r < 32; r++) pend_r[r] <= pend_nxt_s[r];
    end
  end

  // Divider countdown ignores cache stalls; an exception aborts it
  always_comb begin
    if (M_except) begin
      div_nxt_s = DIV_ZERO;
    end else if (issue_s[0] && D_div_start) begin
      div_nxt_s = DIV_LOAD;
    end else if (div_cnt_r != DIV_ZERO) begin
      div_nxt_s = div_cnt_r - DIV_ONE;
    end else begin
      div_nxt_s = div_cnt_r;
    end
  end

  // Divider counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_r <= DIV_ZERO;
    end else begin
      div_cnt_r <= div_nxt_s;
    end
  end

  assign D_issue       = issue_s;
  assign lw_stall      = D_valid[0] & hz_s[0];
  assign longest_stall = longest_s;
  assign F_ena         = ~(lw_stall | longest_s);
  assign D_ena         = ~(lw_stall | longest_s);
  assign E_ena         = ~longest_s;
  assign M_ena         = ~longest_s;
  assign W_ena         = ~longest_s;
  assign F_flush       = 1'b0;
  assign W_flush       = 1'b0;
  assign D_flush       = M_except | E_branch_taken;
  assign E_flush       = M_except | E_branch_taken;
  assign M_flush       = M_except;

`ifdef HAZARD_PERF_EN
  logic [ISSUE_W-1:0] contig_s;
  logic [31:0]        perf_lw_r;
  logic [31:0]        perf_div_r;
  logic [31:0]        perf_part_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? (v + 32'd1) : v;
  endfunction

  // Valid slots up to the first hole: what a full issue would look like
  always_comb begin
    contig_s    = '0;
    contig_s[0] = D_valid[0];
    for (int i = 1; i < ISSUE_W; i++) contig_s[i] = contig_s[i-1] & D_valid[i];
  end

  // Saturating performance counters, untouched by flushes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_lw_r   <= 32'd0;
      perf_div_r  <= 32'd0;
      perf_part_r <= 32'd0;
    end else begin
      perf_lw_r   <= sat_inc(perf_lw_r, lw_stall & ~longest_s);
      perf_div_r  <= sat_inc(perf_div_r, div_busy);
      perf_part_r <= sat_inc(perf_part_r, issue_s[0] & (issue_s != contig_s));
    end
  end

  assign perf_lw_stall_cnt      = perf_lw_r;
  assign perf_div_stall_cnt     = perf_div_r;
  assign perf_partial_issue_cnt = perf_part_r;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (ISSUE_W=2, LOAD_LAT=2, DIV_CYCLES=32).
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       resetn;
  logic       i_stall, d_stall;
  logic [1:0] D_valid;
  logic [9:0] D_rs, D_rt, D_waddr;
  logic [1:0] D_is_load;
  logic       D_div_start, E_branch_taken, M_except;
  logic [1:0] D_issue;
  logic       lw_stall, div_busy, longest_stall;
  logic       F_ena, D_ena, E_ena, M_ena, W_ena;
  logic       F_flush, D_flush, E_flush, M_flush, W_flush;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lw_stall_cnt, perf_div_stall_cnt, perf_partial_issue_cnt;
`endif

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int busy_cycles;
  logic ena_bad;

  hazard_scoreboard #(.ISSUE_W(2), .LOAD_LAT(2), .DIV_CYCLES(32)) dut (
    .clk(clk), .resetn(resetn), .i_stall(i_stall), .d_stall(d_stall),
    .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt), .D_waddr(D_waddr),
    .D_is_load(D_is_load), .D_div_start(D_div_start),
    .E_branch_taken(E_branch_taken), .M_except(M_except),
    .D_issue(D_issue), .lw_stall(lw_stall), .div_busy(div_busy),
    .longest_stall(longest_stall),
    .F_ena(F_ena), .D_ena(D_ena), .E_ena(E_ena), .M_ena(M_ena), .W_ena(W_ena),
    .F_flush(F_flush), .D_flush(D_flush), .E_flush(E_flush), .M_flush(M_flush),
    .W_flush(W_flush)
`ifdef HAZARD_PERF_EN
    ,
    .perf_lw_stall_cnt(perf_lw_stall_cnt),
    .perf_div_stall_cnt(perf_div_stall_cnt),
    .perf_partial_issue_cnt(perf_partial_issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bundle(input logic [1:0] v,
                        input int rs0, input int rt0, input int w0, input logic l0,
                        input int rs1, input int rt1, input int w1, input logic l1);
    D_valid   = v;
    D_rs      = {5'(rs1), 5'(rs0)};
    D_rt      = {5'(rt1), 5'(rt0)};
    D_waddr   = {5'(w1), 5'(w0)};
    D_is_load = {l1, l0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; i_stall = 1'b0; d_stall = 1'b0;
    D_div_start = 1'b0; E_branch_taken = 1'b0; M_except = 1'b0;
    bundle(2'b11, 1, 2, 0, 1'b0, 3, 4, 0, 1'b0);
    #12;
    check("rst_div_busy", div_busy, 0);
    check("rst_lw_stall", lw_stall, 0);
    check("rst_issue", D_issue, 2'b11);
    check("rst_enables", {F_ena, D_ena, E_ena, M_ena, W_ena}, 5'b11111);
    check("rst_flushes", {F_flush, D_flush, E_flush, M_flush, W_flush}, 5'b00000);
    @(negedge clk);
    resetn = 1'b1;

    // load-use on $5: two stall cycles, then issue
    tick(); bundle(2'b01, 29, 0, 5, 1'b1, 0, 0, 0, 1'b0); #1;
    check("lu_issue_lw", D_issue, 2'b01);
    tick(); bundle(2'b11, 5, 1, 6, 1'b0, 2, 3, 4, 1'b0); #1;
    check("lu_stall1", lw_stall, 1);
    check("lu_dena1", {F_ena, D_ena}, 2'b00);
    check("lu_issue1", D_issue, 2'b00);
    check("lu_eena1", E_ena, 1);
    tick(); #1;
    check("lu_stall2", lw_stall, 1);
    check("lu_dena2", D_ena, 0);
    tick(); #1;
    check("lu_stall3", lw_stall, 0);
    check("lu_issue3", D_issue, 2'b11);
    check("lu_dena3", D_ena, 1);

    // intra-bundle dependence
    tick(); bundle(2'b11, 1, 2, 3, 1'b0, 3, 4, 8, 1'b0); #1;
    check("dep_issue", D_issue, 2'b01);
    check("dep_dena", D_ena, 1);
    tick(); bundle(2'b11, 1, 2, 3, 1'b0, 10, 11, 8, 1'b0); #1;
    check("indep_issue", D_issue, 2'b11);
    tick(); bundle(2'b10, 1, 2, 3, 1'b0, 10, 11, 8, 1'b0); #1;
    check("hole_issue", D_issue, 2'b00);
    check("hole_lw_stall", lw_stall, 0);
    tick(); bundle(2'b11, 1, 2, 0, 1'b0, 0, 0, 9, 1'b0); #1;
    check("zero_reg_issue", D_issue, 2'b11);

    // load issued from slot 1
    tick(); bundle(2'b11, 1, 2, 3, 1'b0, 4, 5, 12, 1'b1); #1;
    check("s1_load_issue", D_issue, 2'b11);
    tick(); bundle(2'b01, 12, 0, 13, 1'b0, 0, 0, 0, 1'b0); #1;
    check("s1_load_stall1", lw_stall, 1);
    tick(); #1;
    check("s1_load_stall2", lw_stall, 1);
    tick(); #1;
    check("s1_load_release", lw_stall, 0);
    check("s1_load_use_issue", D_issue, 2'b01);

    // cache-stall freeze of the scoreboard
    tick(); bundle(2'b01, 29, 0, 7, 1'b1, 0, 0, 0, 1'b0); #1;
    check("cs_issue_lw", D_issue, 2'b01);
    tick(); bundle(2'b01, 7, 1, 8, 1'b0, 0, 0, 0, 1'b0); #1;
    check("cs_stall_pre", lw_stall, 1);
    tick(); i_stall = 1'b1; #1;
    check("cs_longest", longest_stall, 1);
    check("cs_ena", {F_ena, D_ena, E_ena, M_ena, W_ena}, 5'b00000);
    check("cs_issue", D_issue, 2'b00);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("cs_hold", lw_stall, 1);
    end
    tick(); i_stall = 1'b0; #1;
    check("cs_after_stall", lw_stall, 1);
    check("cs_after_eena", E_ena, 1);
    check("cs_after_dena", D_ena, 0);
    tick(); #1;
    check("cs_release", lw_stall, 0);
    check("cs_release_issue", D_issue, 2'b01);

    tick(); bundle(2'b01, 1, 2, 0, 1'b0, 0, 0, 0, 1'b0); d_stall = 1'b1; #1;
    check("ds_longest", longest_stall, 1);
    check("ds_issue", D_issue, 2'b00);
    check("ds_wena", W_ena, 0);
    tick(); d_stall = 1'b0;

    // exception clears the scoreboard
    bundle(2'b01, 29, 0, 9, 1'b1, 0, 0, 0, 1'b0); #1;
    check("ex_issue_lw", D_issue, 2'b01);
    tick(); bundle(2'b01, 9, 0, 10, 1'b0, 0, 0, 0, 1'b0); M_except = 1'b1; #1;
    check("ex_flushes", {F_flush, D_flush, E_flush, M_flush, W_flush}, 5'b01110);
    check("ex_issue", D_issue, 2'b00);
    tick(); M_except = 1'b0; #1;
    check("ex_no_stall", lw_stall, 0);
    check("ex_use_issue", D_issue, 2'b01);
    check("ex_flush_off", D_flush, 0);

    tick(); bundle(2'b11, 1, 2, 0, 1'b0, 3, 4, 0, 1'b0); E_branch_taken = 1'b1; #1;
    check("br_flushes", {F_flush, D_flush, E_flush, M_flush, W_flush}, 5'b01100);
    check("br_issue", D_issue, 2'b00);
    tick(); E_branch_taken = 1'b0;

    // divider busy window
    bundle(2'b01, 1, 2, 0, 1'b0, 0, 0, 0, 1'b0); D_div_start = 1'b1; #1;
    check("div_issue", D_issue, 2'b01);
    check("div_idle", div_busy, 0);
    tick(); D_div_start = 1'b0;
    busy_cycles = 0;
    ena_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!div_busy) break;
      busy_cycles++;
      if (E_ena !== 1'b0 || D_issue !== 2'b00 || longest_stall !== 1'b1) ena_bad = 1'b1;
      tick();
    end
    check("div_busy_cycles", busy_cycles, 32);
    check("div_stall_shape", ena_bad, 0);
    check("div_done_eena", E_ena, 1);

    D_div_start = 1'b1; #1;
    check("div2_issue", D_issue, 2'b01);
    tick(); D_div_start = 1'b0;
    repeat (9) tick();
    M_except = 1'b1; #1;
    check("div_abort_pre", div_busy, 1);
    tick(); M_except = 1'b0; #1;
    check("div_abort_busy", div_busy, 0);
    check("div_abort_eena", E_ena, 1);

    // async reset in the middle of a divide with a load pending
    bundle(2'b11, 1, 2, 0, 1'b0, 29, 0, 20, 1'b1); D_div_start = 1'b1; #1;
    check("rd_issue", D_issue, 2'b11);
    tick(); D_div_start = 1'b0; bundle(2'b01, 20, 0, 21, 1'b0, 0, 0, 0, 1'b0); #1;
    check("rd_busy", div_busy, 1);
    check("rd_lw_stall", lw_stall, 1);
    repeat (15) tick();
    #1;
    check("rd_lw_hold", lw_stall, 1);
    resetn = 1'b0; #1;
    check("rd_div_busy", div_busy, 0);
    check("rd_longest", longest_stall, 0);
    check("rd_pend_clear", lw_stall, 0);
    check("rd_issue_after", D_issue, 2'b01);
    @(negedge clk);
    resetn = 1'b1;
    tick(); #1;
    check("rd_post_busy", div_busy, 0);
    check("rd_post_lw", lw_stall, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor of the pipeline hazard unit for the N-wide in-order MIPS core.
- Replaces pure comparator load-use detection with a per-register pending-load scoreboard.
- Adds per-slot issue masking for intra-bundle dependences and an internal divider busy counter.
- Produces the same F..W enable/flush set consumed by the pipeline registers.

Parameters:
- ISSUE_W, 2, issue slots in D; slot 0 is master, slots 1..ISSUE_W-1 are slaves in program order.
- LOAD_LAT, 2, cycles a load's destination stays unforwardable after issue (E and M stages).
- DIV_CYCLES, 32, cycles the divider stalls the pipe after a divide issues.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- i_stall  in  1  instruction cache miss stall
- d_stall  in  1  data cache miss stall
- D_valid  in  ISSUE_W  slot i holds a valid instruction
- D_rs  in  5*ISSUE_W  source rs per slot; slot i occupies bits [5i+4:5i]
- D_rt  in  5*ISSUE_W  source rt per slot
- D_waddr  in  5*ISSUE_W  destination register per slot (0 = none)
- D_is_load  in  ISSUE_W  slot i is a load
- D_div_start  in  1  slot 0 is a div/divu
- E_branch_taken  in  1  branch resolved taken in E
- M_except  in  1  exception committed in M
- D_issue  out  ISSUE_W  slot i leaves D this cycle
- lw_stall  out  1  slot 0 blocked by a pending load
- div_busy  out  1  divider counter nonzero
- longest_stall  out  1  i_stall | d_stall | div_busy
- F_ena, D_ena, E_ena, M_ena, W_ena  out  1 each  stage enables
- F_flush, D_flush, E_flush, M_flush, W_flush  out  1 each  stage flushes

Behaviour:
- Reset (resetn low, async):
  - all 32 pending counters = 0 and div_cnt = 0;
  - hence div_busy = 0, lw_stall = 0, D_issue = slots with D_valid=1 (no hazards).
- pend[r]: width clog2(LOAD_LAT+1); register r is hazardous when pend[r] != 0. pend[0] is held at 0.
- hz(i): slot i reads rs or rt with pend != 0.
- dep(i): slot i reads rs or rt equal to a nonzero D_waddr of any earlier slot j<i with D_valid[j].
- Issue mask (combinational):
  - D_issue[0] = D_valid[0] & ~hz(0) & ~longest_stall & ~E_branch_taken & ~M_except.
  - D_issue[i>0] = D_issue[i-1] & D_valid[i] & ~hz(i) & ~dep(i).
  - An invalid slot blocks all later slots.
- lw_stall = D_valid[0] & hz(0).
- Enables:
  - F_ena = D_ena = ~(lw_stall | longest_stall).
  - E_ena = M_ena = W_ena = ~longest_stall.
  - Partial issue keeps D_ena=1; the fetch queue consumes popcount(D_issue) entries.
- Flushes:
  - F_flush = 0, W_flush = 0.
  - D_flush = E_flush = M_except | E_branch_taken.
  - M_flush = M_except.
- Scoreboard update (posedge clk):
  - Each cycle with ~longest_stall, every nonzero pend decrements by 1.
  - For each i with D_issue[i] & D_is_load[i] & D_waddr[i]!=0: pend[D_waddr[i]] <= LOAD_LAT. Set overrides a same-cycle decrement.
  - Two issuing loads with the same waddr: the later slot wins (value is identical).
  - M_except: all pend <= 0; this overrides any set in the same cycle.
  - While longest_stall = 1, pend holds.
- Divider counter:
  - div_cnt width clog2(DIV_CYCLES+1).
  - Loads DIV_CYCLES when D_issue[0] & D_div_start.
  - When nonzero, decrements every cycle regardless of i_stall/d_stall.
  - div_busy = (div_cnt != 0).
  - M_except clears div_cnt (abort).
  - A new div cannot issue while div_busy, since longest_stall blocks D_issue.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds outputs:
  - perf_lw_stall_cnt [31:0]: +1 per cycle with lw_stall & ~longest_stall;
  - perf_div_stall_cnt [31:0]: +1 per cycle with div_busy;
  - perf_partial_issue_cnt [31:0]: +1 per cycle with D_issue[0]=1 and D_issue != ((D_valid) masked to contiguous valid slots).
- Counters reset to 0, saturate at 0xFFFFFFFF, and are unaffected by flushes.
- When not defined, these ports and registers do not exist.

Test Plan:
- Load-use: slot0 lw $5, next cycle slot0 add $6,$5,$1 → lw_stall=1 and D_ena=0 for 2 cycles, D_issue[0]=1 on the 3rd.
- Intra-bundle dependence: slot0 addu $3, slot1 uses $3, no pending → D_issue=2'b01, D_ena=1. Next bundle with independent slot1 → D_issue=2'b11.
- Divide: div issues with DIV_CYCLES=32 → div_busy and longest_stall high for exactly 32 cycles; E_ena=0 throughout. M_except at cycle 10 → div_busy=0 next cycle.
- Cache stall freeze: lw $7 issues, i_stall high 5 cycles → pend[$7] holds at 1 through the stall; lw_stall on $7 releases 1 cycle after i_stall drops.
- Exception clear: lw $9 issued, M_except next cycle → pend[$9]=0, D_flush=E_flush=M_flush=1, no lw_stall on a following use of $9.
- Async reset mid-divide (div_cnt=17) → div_busy=0 immediately, all pend=0.
